// File: rtl/bsk_led_stretch.sv
// LED pulse stretcher: each of 32 command flags stays lit for HOLD prescaled
// ticks after it drops; iTest forces every output on without disturbing the holds.

module bsk_led_stretch_ch #(
  parameter int HOLD = 4,
  parameter int CW   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd,
  input  logic tick,
  input  logic test,
  output logic led
);
  logic [CW-1:0] cnt, cnt_nxt;

  // Reload beats decrement so a command on a tick edge restarts the full hold.
  always_comb begin
    cnt_nxt = cnt;
    if (cmd)
      cnt_nxt = CW'(HOLD);
    else if (tick && cnt != '0)
      cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      led <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      led <= (cnt_nxt != '0) | test;
    end
  end
endmodule

module bsk_led_stretch #(
  parameter int PRESCALE = 1000,
  parameter int HOLD     = 4
) (
  input  logic        clk,
  input  logic        iRst_n,
  input  logic [15:0] iCmdPrd,
  input  logic [15:0] iCmdPrm,
  input  logic        iTest,
  output logic [15:0] oLedPrd,
  output logic [15:0] oLedPrm
);
  localparam int NUM_LANES = 32;
  localparam int CW = $clog2(HOLD + 1);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]        pre;
  logic                 tick;
  logic [NUM_LANES-1:0] cmd;
  logic [NUM_LANES-1:0] led;

  // With PRESCALE=1 the counter sits at 0 and the compare is always true.
  assign tick = (pre == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) pre <= '0;
    else         pre <= tick ? '0 : pre + PW'(1);
  end

  assign cmd = {iCmdPrm, iCmdPrd};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_ch
    bsk_led_stretch_ch #(.HOLD(HOLD), .CW(CW)) u_ch (
      .clk  (clk),
      .rst_n(iRst_n),
      .cmd  (cmd[i]),
      .tick (tick),
      .test (iTest),
      .led  (led[i])
    );
  end

  assign oLedPrd = led[15:0];
  assign oLedPrm = led[31:16];
endmodule

// File: tb/tb_bsk_led_stretch.sv
// Scoreboard bench: a tick-arithmetic model predicts each edge's outputs,
// a monitor compares them one step after every rising edge.

module tb_bsk_led_stretch;
  localparam int P = 4;
  localparam int H = 3;

  typedef struct packed {
    logic [15:0] prd;
    logic [15:0] prm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd_prd = '0, cmd_prm = '0;
  logic        test = 1'b0;
  logic [15:0] led_prd, led_prm;

  int total = 0, bad = 0;
  exp_t q[$];

  // Model state: edge count since reset release and last reload edge per channel.
  int n = 0;
  int lastr[32];

  bsk_led_stretch #(.PRESCALE(P), .HOLD(H)) dut (
    .clk    (clk),
    .iRst_n (rst_n),
    .iCmdPrd(cmd_prd),
    .iCmdPrm(cmd_prm),
    .iTest  (test),
    .oLedPrd(led_prd),
    .oLedPrm(led_prm)
  );

  always #5 clk = ~clk;

  // Ticks land on edges that are multiples of P; a channel is lit while fewer
  // than H ticks have occurred after its last reload edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      for (int c = 0; c < 32; c++) lastr[c] = -1;
      q.delete();
    end else begin
      logic [31:0] in, o;
      exp_t e;
      n++;
      in = {cmd_prm, cmd_prd};
      for (int c = 0; c < 32; c++) begin
        if (in[c]) lastr[c] = n;
        o[c] = test || (lastr[c] >= 0 && (n / P - lastr[c] / P) < H);
      end
      e.prd = o[15:0];
      e.prm = o[31:16];
      q.push_back(e);
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      total++;
      if (led_prd != '0 || led_prm != '0) begin
        bad++;
        $display("FAIL reset_state: got prd=%h prm=%h want 0000/0000", led_prd, led_prm);
      end
    end else if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (led_prd != e.prd || led_prm != e.prm) begin
        bad++;
        $display("FAIL edge%0d: got prd=%h prm=%h want prd=%h prm=%h",
                 n, led_prd, led_prm, e.prd, e.prm);
      end
    end
  end

  // Called at a falling edge; holds the values for k rising edges.
  task automatic drive(input logic [15:0] p, input logic [15:0] m, input logic t, input int k);
    cmd_prd = p; cmd_prm = m; test = t;
    repeat (k) @(negedge clk);
  endtask

  task automatic rst_pulse();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (led_prd != '0 || led_prm != '0) begin
      bad++;
      $display("FAIL async_reset: got prd=%h prm=%h want 0000/0000", led_prd, led_prm);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    for (int c = 0; c < 32; c++) lastr[c] = -1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // Reload on the first tick edge (edge 4).
    drive(16'h0000, 16'h0000, 1'b0, 3);
    drive(16'h0001, 16'h0000, 1'b0, 1);
    drive(16'h0000, 16'h0000, 1'b0, 16);
    // Fresh alignment, then receiver pulse on edge 5.
    rst_pulse();
    drive(16'h0000, 16'h0000, 1'b0, 4);
    drive(16'h0000, 16'h8000, 1'b0, 1);
    drive(16'h0000, 16'h0000, 1'b0, 16);
    // Long hold then release.
    drive(16'hAAAA, 16'h0000, 1'b0, 20);
    drive(16'h0000, 16'h0000, 1'b0, 16);
    // Lamp test alone, then during a hold.
    drive(16'h0000, 16'h0000, 1'b1, 3);
    drive(16'h0000, 16'h0000, 1'b0, 3);
    drive(16'h0000, 16'h0010, 1'b0, 1);
    drive(16'h0000, 16'h0000, 1'b1, 3);
    drive(16'h0000, 16'h0000, 1'b0, 14);
    // Reset mid-hold; input already high at release.
    drive(16'h1234, 16'h4321, 1'b0, 2);
    rst_pulse();
    drive(16'h0300, 16'h0000, 1'b0, 1);
    drive(16'h0000, 16'h0000, 1'b0, 14);
    // Randomized sparse commands, occasional lamp test and reset.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] p, m;
      p = 16'($urandom) & 16'($urandom) & 16'($urandom);
      m = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin p = '0; m = '0; end
      if ($urandom_range(0, 99) == 0) rst_pulse();
      drive(p, m, ($urandom_range(0, 15) == 0), $urandom_range(1, 6));
    end
    drive(16'h0000, 16'h0000, 1'b0, 16);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
